// File: rtl/pdm_decoder.sv
// pdm_decoder: boxcar PDM-to-PCM decimator over 2^K bits with a 1-deep
// valid/ready output register; define PDM_DEC_SYNC_EN for a 2-flop input sync.
module pdm_decoder #(
  parameter int N = 16,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_en,
  input  logic         pdm_in,
  output logic [N-1:0] pcm_out,
  output logic         pcm_valid,
  input  logic         pcm_ready,
  output logic         overrun,
  input  logic         overrun_clr
);

  logic         bit_in;
  logic [K-1:0] win_cnt;
  logic [K:0]   ones_cnt;
  logic [K:0]   count;
  logic         done;
  logic         xfer;
  logic [N-1:0] scaled;

`ifdef PDM_DEC_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // Free-running synchronizer for an asynchronous PDM source
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pdm_in;
      sync_q2 <= sync_q1;
    end
  end

  assign bit_in = sync_q2;
`else
  assign bit_in = pdm_in;
`endif

  assign count = ones_cnt + {{K{1'b0}}, bit_in};
  assign done  = sample_en && (win_cnt == {K{1'b1}});
  assign xfer  = pcm_valid && pcm_ready;

  // Full window of ones saturates; otherwise left-justify the count
  always_comb begin
    scaled = '0;
    if (count[K]) begin
      scaled = '1;
    end else begin
      scaled = N'(count[K-1:0]) << (N - K);
    end
  end

  // Window and ones counters advance only on strobed bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      ones_cnt <= '0;
    end else if (sample_en) begin
      win_cnt  <= win_cnt + K'(1);
      ones_cnt <= done ? '0 : count;
    end
  end

  // Output register: latest sample wins, overrun flags a lost sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (done) begin
        pcm_out   <= scaled;
        pcm_valid <= 1'b1;
      end else if (xfer) begin
        pcm_valid <= 1'b0;
      end
      if (done && pcm_valid && !pcm_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_decoder.sv
// tb_pdm_decoder: randomized and directed checks of pdm_decoder
// against a window-sum reference model; also a modulator loopback.
module tb_pdm_decoder;

  localparam int NN = 8;
  localparam int KK = 4;
  localparam int WIN = 1 << KK;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_en = 1'b0;
  logic pdm_in = 1'b0;
  logic pcm_ready = 1'b0;
  logic overrun_clr = 1'b0;
  logic [NN-1:0] pcm_out;
  logic pcm_valid;
  logic overrun;

  logic lb_en = 1'b0;
  logic lb_pdm = 1'b0;
  logic [7:0] lb_pcm;
  logic lb_valid;
  logic lb_ovr;

  int checks = 0;
  int errors = 0;

  int q[$];
  int m_pcm = 0;
  logic m_valid = 1'b0;
  logic m_ovr = 1'b0;
  logic h1 = 1'b0;
  logic h2 = 1'b0;

  always #5 clk = ~clk;

  pdm_decoder #(.N(NN), .K(KK)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_en(sample_en),
    .pdm_in(pdm_in),
    .pcm_out(pcm_out),
    .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready),
    .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  pdm_decoder #(.N(8), .K(8)) u_lb (
    .clk(clk),
    .rst_n(rst_n),
    .sample_en(lb_en),
    .pdm_in(lb_pdm),
    .pcm_out(lb_pcm),
    .pcm_valid(lb_valid),
    .pcm_ready(1'b1),
    .overrun(lb_ovr),
    .overrun_clr(1'b0)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference: collect taken bits, sum a full window, scale arithmetically
  task automatic model_edge();
    logic b;
    int c;
    int nv;
    bit fin;
    bit lost;
    bit tx;
    if (!rst_n) begin
      q.delete();
      m_pcm = 0;
      m_valid = 1'b0;
      m_ovr = 1'b0;
      h1 = 1'b0;
      h2 = 1'b0;
      return;
    end
`ifdef PDM_DEC_SYNC_EN
    b = h2;
`else
    b = pdm_in;
`endif
    h2 = h1;
    h1 = pdm_in;
    fin = 0;
    nv = 0;
    if (sample_en) begin
      q.push_back(int'(b));
      if (q.size() == WIN) begin
        c = 0;
        foreach (q[i]) c += q[i];
        nv = (c == WIN) ? (1 << NN) - 1 : c * (1 << (NN - KK));
        q.delete();
        fin = 1;
      end
    end
    tx = m_valid && pcm_ready;
    lost = fin && m_valid && !tx;
    if (fin) begin
      m_pcm = nv;
      m_valid = 1'b1;
    end else if (tx) begin
      m_valid = 1'b0;
    end
    if (lost) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
  endtask

  task automatic cyc(input logic en, input logic p,
                     input logic rdy, input logic clr);
    sample_en = en;
    pdm_in = p;
    pcm_ready = rdy;
    overrun_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    check("valid", int'(pcm_valid), int'(m_valid));
    check("overrun", int'(overrun), int'(m_ovr));
    if (m_valid) check("pcm", int'(pcm_out), m_pcm);
  endtask

  task automatic window(input int pat, input logic rdy_last);
    for (int i = 0; i < WIN; i++) begin
      logic p;
      case (pat)
        0: p = 1'b0;
        1: p = 1'b1;
        default: p = (i % 2 == 0);
      endcase
      cyc(1'b1, p, (i == WIN - 1) ? rdy_last : 1'b0, 1'b0);
    end
  endtask

  initial begin
    int nlb;
    int acc;
    int s;
    rst_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_pcm", int'(pcm_out), 0);
    check("rst_valid", int'(pcm_valid), 0);
    check("rst_ovr", int'(overrun), 0);
    rst_n = 1'b1;

    window(1, 1'b0);
    check("ones_pcm", int'(pcm_out), 'hFF);
    check("ones_valid", int'(pcm_valid), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("xfer_valid", int'(pcm_valid), 0);

    window(2, 1'b0);
    check("alt_pcm", int'(pcm_out), 'h80);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    window(0, 1'b0);
    check("zero_pcm", int'(pcm_out), 'h00);
    check("zero_valid", int'(pcm_valid), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 2 * WIN; i++) begin
      cyc(i % 2 == 0, i % 2 == 0, 1'b0, 1'b0);
      if (i == 2 * WIN - 3) check("strobe_early", int'(pcm_valid), 0);
    end
    check("strobe_pcm", int'(pcm_out), 'hFF);
    check("strobe_valid", int'(pcm_valid), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    window(1, 1'b0);
    window(0, 1'b0);
    check("ovr_set", int'(overrun), 1);
    check("ovr_pcm", int'(pcm_out), 'h00);
    check("ovr_valid", int'(pcm_valid), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_drain", int'(pcm_valid), 0);
    check("ovr_hold", int'(overrun), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_clr", int'(overrun), 0);

    window(1, 1'b0);
    window(0, 1'b1);
    check("same_valid", int'(pcm_valid), 1);
    check("same_pcm", int'(pcm_out), 'h00);
    check("same_ovr", int'(overrun), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    window(1, 1'b0);
    for (int i = 0; i < WIN; i++) cyc(1'b1, 1'b1, 1'b0, i == WIN - 1);
    check("setwin_ovr", int'(overrun), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_rst_valid", int'(pcm_valid), 0);
    check("mid_rst_pcm", int'(pcm_out), 0);
    rst_n = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == WIN - 2) check("mid_rst_full", int'(pcm_valid), 0);
    end
    check("mid_rst_pcm2", int'(pcm_out), 'hFF);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, $urandom_range(1, 0) == 1,
          ($urandom % 4) == 0, ($urandom % 16) == 0);
    end

    sample_en = 1'b0;
    pcm_ready = 1'b0;
    overrun_clr = 1'b0;
    nlb = 0;
    acc = 0;
    for (int i = 0; i < 1100; i++) begin
      s = acc + 'h40;
      lb_pdm = (s >= 256);
      acc = s % 256;
      lb_en = 1'b1;
      @(posedge clk);
      #1;
      if (lb_valid) begin
        nlb++;
        check("loop_pcm", int'(lb_pcm), 'h40);
      end
    end
    lb_en = 1'b0;
    check("loop_count", nlb, 1100 / 256);
    check("loop_ovr", int'(lb_ovr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_decoder.md
# pdm_decoder

Converts a 1-bit PDM stream back into N-bit PCM samples by counting ones over a fixed window of 2^K stream bits (boxcar decimation). It sits at the receive end of the team's first-order PDM modulator, for loopback and audio/ADC front-ends. Decoded samples are delivered through a 1-deep valid/ready output register with a sticky overrun flag.

## Interface
Parameters:
- N, 16, PCM output width in bits.
- K, 8, log2 of the decimation window (window = 2^K PDM bits); legal range 1 <= K <= N.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- sample_en  input  1  strobe; the PDM bit is taken on edges where it is high.
- pdm_in  input  1  PDM bit stream.
- pcm_out  output  N  decoded sample; valid while pcm_valid=1.
- pcm_valid  output  1  output register holds an unconsumed sample.
- pcm_ready  input  1  consumer accepts; transfer when pcm_valid & pcm_ready.
- overrun  output  1  sticky: a completed sample overwrote an unconsumed one.
- overrun_clr  input  1  clears overrun.

## Operation
- Internal state: window counter win_cnt (K bits), ones counter ones_cnt (K+1 bits), output register, valid, overrun.
- Taken bit b: pdm_in (or synchronized copy, see Configuration) on an edge with sample_en=1. sample_en=0 leaves all counters unchanged.
- Each taken bit: win_cnt increments mod 2^K; ones_cnt += b.
- Window completion: taken bit with win_cnt = 2^K-1. Final count C = ones_cnt + b (0..2^K). At that edge ones_cnt <= 0, win_cnt wraps to 0, output register loads the scaled value.
- Scaling: if C = 2^K, pcm_out = all ones (2^N-1, saturated); else pcm_out = C << (N-K). K=N gives pcm_out = C, saturated at 2^N-1.
- Handshake:
  - pcm_valid rises on completion and holds until a transfer.
  - pcm_out is stable while pcm_valid=1 and no new completion occurs.
  - Transfer without completion: pcm_valid <= 0.
- Boundary cases:
  - Completion and transfer in the same cycle: the old sample is consumed, the new one loads, pcm_valid stays 1, overrun is not set.
  - Completion while pcm_valid=1 and no transfer: the new sample overwrites (latest wins), pcm_valid stays 1, overrun <= 1.
  - overrun_clr and an overrun event in the same cycle: set wins.
  - Reset mid-window discards the partial window; counting restarts from win_cnt=0 after reset.
- No FSM beyond the counters. The output register is the only buffer.

## Timing
- Reset values: pcm_out=0, pcm_valid=0, overrun=0, win_cnt=0, ones_cnt=0, sync flops=0.
- Latency: pcm_valid=1 and pcm_out updated on the clk edge that takes the 2^K-th bit, visible the following cycle. Add 2 clk bit latency with PDM_DEC_SYNC_EN.
- Throughput: one sample per 2^K taken bits. sample_en may be high every cycle.
- pcm_valid and pcm_out are purely registered. pcm_ready has no combinational path to any output.
- overrun_clr takes effect at the next edge.

## Configuration
- PDM_DEC_SYNC_EN defined:
  - pdm_in passes through a 2-flop synchronizer clocked every clk, not gated by sample_en.
  - The bit taken at a sample_en edge is pdm_in as it was 2 clk earlier.
  - Use for an asynchronous PDM source.
- PDM_DEC_SYNC_EN undefined: pdm_in is taken directly; the source must be synchronous to clk.

## Test plan
- N=8, K=4, pdm_in=1, sample_en=1 for 16 cycles -> pcm_out=0xFF, pcm_valid=1 one cycle after the 16th edge.
- N=8, K=4, alternating 1/0 for 16 taken bits -> pcm_out=0x80. All zeros -> pcm_out=0x00.
- sample_en toggling 1/0 with pdm_in=1 -> the sample completes only after 16 strobed bits (32 clk); bits presented on sample_en=0 cycles are ignored.
- pcm_ready=0 through two windows (first all ones, second all zeros):
  - overrun=1, pcm_out=0x00, pcm_valid=1.
  - Then pcm_ready=1 -> pcm_valid=0.
  - Then overrun_clr -> overrun=0.
- Completion on the same edge as a transfer -> pcm_valid stays 1, new value loaded, overrun=0.
- Loopback from the modulator with N=8 and constant input 0x40 into pdm_decoder with N=8, K=8 -> every sample = 0x40.
- Assert rst_n=0 mid-window -> outputs return to reset values; the next sample counts a full 2^K bits.
